// File: rtl/fact_accel_if.sv
// Data-memory bus slice seen by the factorial accelerator: qualified write strobe,
// word select and write data in; combinational read word and status mirrors out.
interface fact_accel_if #(
  parameter int WIDTH = 32,
  parameter int NBITS = 4
);
  logic             we;
  logic [1:0]       a;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             done;
  logic             err;

  modport master (output we, a, wd, input rd, done, err);
  modport slave  (input we, a, wd, output rd, done, err);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: software writes n and GO, polls STATUS,
// then reads n! from RESULT. One WIDTH x NBITS multiply per clock.
module fact_accel #(
  parameter int WIDTH = 32,
  parameter int NBITS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  fact_accel_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [NBITS-1:0] N_MAX = NBITS'(12);
  localparam logic [NBITS-1:0] N_ONE = NBITS'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [NBITS-1:0] r_n;
  logic [NBITS-1:0] r_cnt;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_err;
  logic             w_busy;
  logic             w_go;
  logic [WIDTH-1:0] w_cnt_ext;

  assign w_busy    = (r_state == S_LOAD) || (r_state == S_MUL);
  // GO is only honoured when idle or done; a GO while busy is dropped.
  assign w_go      = bus.we && (bus.a == 2'd1) && bus.wd[0] && !w_busy;
  assign w_cnt_ext = {{(WIDTH-NBITS){1'b0}}, r_cnt};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = w_go ? S_LOAD : S_IDLE;
      S_LOAD:  w_next_state = (r_n > N_MAX) ? S_DONE : S_MUL;
      S_MUL:   w_next_state = (r_cnt <= N_ONE) ? S_DONE : S_MUL;
      S_DONE:  w_next_state = w_go ? S_LOAD : S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand, loop and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n      <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // N stays writable while busy; the loop works from the LOAD snapshot.
      if (bus.we && (bus.a == 2'd0)) begin
        r_n <= bus.wd[NBITS-1:0];
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_cnt  <= r_n;
          r_prod <= WIDTH'(1);
          if (r_n > N_MAX) begin
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_result <= '0;
          end
        end
        S_MUL: begin
          if (r_cnt <= N_ONE) begin
            r_result <= r_prod;
            r_done   <= 1'b1;
          end else begin
            r_prod <= r_prod * w_cnt_ext;
            r_cnt  <= r_cnt - N_ONE;
          end
        end
        default: begin
          r_done <= r_done;
        end
      endcase
    end
  end

  // Read mux and status mirrors
  always_comb begin
    bus.rd   = '0;
    bus.done = r_done;
    bus.err  = r_err;
    case (bus.a)
      2'd0:    bus.rd = {{(WIDTH-NBITS){1'b0}}, r_n};
      2'd1:    bus.rd = {{(WIDTH-1){1'b0}}, w_busy};
      2'd2:    bus.rd = {{(WIDTH-2){1'b0}}, r_err, r_done};
      2'd3:    bus.rd = r_result;
      default: bus.rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboarded bench for fact_accel: expected n! pushed at GO, popped at completion.
module tb_fact_accel;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fact_accel_if #(.WIDTH(32), .NBITS(4)) bus ();

  fact_accel #(.WIDTH(32), .NBITS(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  function automatic logic [31:0] fact_model(input int n);
    logic [31:0] p;
    p = 32'd1;
    if (n > 12) return 32'd0;
    for (int i = 2; i <= n; i++) p = p * i;
    return p;
  endfunction

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.wd = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.a = addr;
    #1;
    data = bus.rd;
  endtask

  task automatic start_job(input int n);
    bus_write(2'd0, n);
    bus_write(2'd1, 32'd1);
    sb.push_back(fact_model(n));
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (bus.done !== 1'b1 && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    bus.we = 1'b0; bus.a = 2'd0; bus.wd = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_read(k[1:0], v);
      n_vec++;
      if (v !== 32'd0) begin n_err++; $display("FAIL reset_rd a=%0d got %h exp 0", k, v); end
    end
    n_vec++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got done=%b err=%b exp 0/0", bus.done, bus.err);
    end
  endtask

  task automatic test_fact5;
    logic [31:0] v, exp_v;
    start_job(5);
    for (int k = 0; k < 6; k++) begin
      bus_read(2'd1, v);
      n_vec++;
      if (v !== 32'd1 || bus.done !== 1'b0) begin
        n_err++; $display("FAIL f5_busy step %0d got busy=%h done=%b exp 1/0", k, v, bus.done);
      end
      @(posedge clk);
      #1;
    end
    bus_read(2'd2, v);
    n_vec++;
    if (v !== 32'd1) begin n_err++; $display("FAIL f5_status got %h exp 1", v); end
    bus_read(2'd1, v);
    n_vec++;
    if (v !== 32'd0) begin n_err++; $display("FAIL f5_idle_busy got %h exp 0", v); end
    bus_read(2'd3, v);
    exp_v = sb.pop_front();
    n_vec++;
    if (v !== exp_v || v !== 32'd120) begin n_err++; $display("FAIL f5_result got %h exp %h", v, exp_v); end
  endtask

  task automatic test_small;
    logic [31:0] v, exp_v;
    int cyc;
    for (int n = 0; n < 2; n++) begin
      start_job(n);
      wait_done(0, cyc);
      n_vec++;
      if (cyc !== 2) begin n_err++; $display("FAIL small_latency n=%0d got %0d exp 2", n, cyc); end
      bus_read(2'd3, v);
      exp_v = sb.pop_front();
      n_vec++;
      if (v !== exp_v) begin n_err++; $display("FAIL small_result n=%0d got %h exp %h", n, v, exp_v); end
    end
  endtask

  task automatic test_n12_n13;
    logic [31:0] v, exp_v;
    int cyc;
    start_job(12);
    wait_done(0, cyc);
    n_vec++;
    if (cyc !== 13) begin n_err++; $display("FAIL n12_latency got %0d exp 13", cyc); end
    bus_read(2'd3, v);
    exp_v = sb.pop_front();
    n_vec++;
    if (v !== exp_v || v !== 32'h1C8C_FC00) begin n_err++; $display("FAIL n12_result got %h exp %h", v, exp_v); end
    start_job(13);
    wait_done(0, cyc);
    n_vec++;
    if (cyc !== 1) begin n_err++; $display("FAIL n13_latency got %0d exp 1", cyc); end
    bus_read(2'd2, v);
    n_vec++;
    if (v !== 32'd3 || bus.err !== 1'b1) begin n_err++; $display("FAIL n13_status got %h err=%b exp 3/1", v, bus.err); end
    bus_read(2'd3, v);
    exp_v = sb.pop_front();
    n_vec++;
    if (v !== exp_v) begin n_err++; $display("FAIL n13_result got %h exp %h", v, exp_v); end
  endtask

  task automatic test_busy_writes;
    logic [31:0] v, exp_v;
    int cyc;
    start_job(6);
    repeat (2) begin @(posedge clk); #1; end
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd3);
    wait_done(4, cyc);
    n_vec++;
    if (cyc !== 7) begin n_err++; $display("FAIL busy_latency got %0d exp 7", cyc); end
    bus_read(2'd3, v);
    exp_v = sb.pop_front();
    n_vec++;
    if (v !== exp_v || v !== 32'd720) begin n_err++; $display("FAIL busy_result got %h exp %h", v, exp_v); end
    bus_read(2'd0, v);
    n_vec++;
    if (v !== 32'd3) begin n_err++; $display("FAIL busy_n_readback got %h exp 3", v); end
    bus_write(2'd1, 32'd1);
    sb.push_back(fact_model(3));
    wait_done(0, cyc);
    bus_read(2'd3, v);
    exp_v = sb.pop_front();
    n_vec++;
    if (v !== exp_v || cyc !== 4) begin n_err++; $display("FAIL later_go got %h in %0d exp %h in 4", v, cyc, exp_v); end
  endtask

  task automatic test_ignored_and_back_to_back;
    logic [31:0] v, exp_v;
    int cyc;
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'h1234_5678);
    bus_read(2'd2, v);
    n_vec++;
    if (v !== 32'd1) begin n_err++; $display("FAIL ign_status got %h exp 1", v); end
    bus_read(2'd3, v);
    n_vec++;
    if (v !== 32'd6) begin n_err++; $display("FAIL ign_result got %h exp 6", v); end
    bus_read(2'd1, v);
    n_vec++;
    if (v !== 32'd0) begin n_err++; $display("FAIL ign_busy got %h exp 0", v); end
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'd1);
    sb.push_back(fact_model(4));
    n_vec++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_done_clear got %b exp 0", bus.done); end
    bus_read(2'd3, v);
    n_vec++;
    if (v !== 32'd6) begin n_err++; $display("FAIL b2b_old_result got %h exp 6", v); end
    bus_read(2'd1, v);
    n_vec++;
    if (v !== 32'd1) begin n_err++; $display("FAIL b2b_busy got %h exp 1", v); end
    wait_done(0, cyc);
    bus_read(2'd3, v);
    exp_v = sb.pop_front();
    n_vec++;
    if (v !== exp_v || cyc !== 5) begin n_err++; $display("FAIL b2b_result got %h in %0d exp %h in 5", v, cyc, exp_v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    bus_write(2'd0, 32'd7);
    bus_write(2'd1, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_read(k[1:0], v);
      n_vec++;
      if (v !== 32'd0) begin n_err++; $display("FAIL midrst_rd a=%0d got %h exp 0", k, v); end
    end
    n_vec++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_err++; $display("FAIL midrst_flags got done=%b err=%b exp 0/0", bus.done, bus.err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fact5();
    test_small();
    test_n12_n13();
    test_busy_writes();
    test_ignored_and_back_to_back();
    test_reset_mid();
    n_vec++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
# fact_accel

Memory-mapped factorial accelerator on the single-cycle MIPS core's data-memory bus. It sits directly downstream of the datapath: it consumes the datapath's address (`aluout`), `writedata` and `memwrite`, and returns a read word that is muxed into `readdata`. Software writes n and a GO command, polls status, then reads n!. The computation is an iterative multiply loop, one multiply per clock.

## Interface
- WIDTH, 32, data/result width.
- NBITS, 4, width of the n operand.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  write enable; already qualified by the system address decoder (memwrite & accelerator selected).
- a  in  2  word select, driven from aluout[3:2].
- wd  in  WIDTH  write data, from datapath writedata.
- rd  out  WIDTH  combinational read data for the selected register.
- done  out  1  mirror of status.done.
- err  out  1  mirror of status.err.

## Operation
- Register map, selected by a:
  - 0: N, R/W. Holds wd[NBITS-1:0]. Reads as {zero-extend, n}.
  - 1: GO, W. A write with wd[0]=1 starts a computation. Reads as {31'b0, busy}, where busy means state is LOAD or MUL.
  - 2: STATUS, R. Reads as {30'b0, err, done}. Writes are ignored.
  - 3: RESULT, R. Reads as the result register. Writes are ignored.
- FSM states: IDLE, LOAD, MUL, DONE. Reset state is IDLE.
  - IDLE or DONE, GO write with wd[0]=1: go to LOAD and clear done and err. A GO write with wd[0]=0 is ignored.
  - LOAD: capture cnt<=n and prod<=1.
    - If n>12, go to DONE with err<=1 and result<=0.
    - Otherwise go to MUL.
  - MUL, cnt<=1: go to DONE with result<=prod and done<=1.
  - MUL, otherwise: prod<=prod*cnt (truncated to WIDTH bits) and cnt<=cnt-1.
  - DONE: hold until the next GO.
- Width rule: the multiplier is WIDTH x NBITS. Because n≤12, 12!=479001600 fits in 32 bits and no truncation occurs on valid inputs.
- A GO write while busy is ignored and does not restart the computation.
- A write to N while busy updates the N register only. The in-flight computation uses the cnt/prod snapshot taken in LOAD.
- RESULT keeps its previous value until the next transition into DONE.
- Reset values: n=0, cnt=0, prod=0, result=0, done=0, err=0, state=IDLE. With a=0 after reset, rd=0.
- Reset asserted mid-operation aborts immediately. Every register returns to its reset value and no result is written.

## Timing
- rd is combinational from a and the register contents, so a same-cycle load matches single-cycle core timing. Writes take effect at the clock edge on which we=1.
- Let E0 be the edge that accepts GO. The state is LOAD after E0 and MUL or DONE after E1.
- done=1 and RESULT are valid after edge E(max(n,1)+1).
  - n=5: done after E6.
  - n=0 or n=1: done after E2 with result 1.
- Error case (n>12): done=1, err=1 and result=0 after E1. err implies done.
- busy reads 1 from after E0 until the edge that enters DONE.
- A GO accepted in DONE clears done/err after E0, while RESULT still shows the old value until the new completion.

## Test plan
- Reset held low, then released: rd=0 for a=0..3, done=0, err=0. Assert reset again mid-MUL: everything returns to zero immediately, asynchronously to clk.
- Write N=5, then GO=1: busy=1 during E0..E5, done=1 after E6, RESULT=120 (0x78), err=0.
- N=0, then N=1, each followed by GO: RESULT=1 after E2 in both cases.
- N=12 with GO: RESULT=0x1C8CFC00 after E13. Then N=13 with GO: err=1, done=1, RESULT=0 after E1.
- N=6 with GO; at E3 write GO=1 again and N=3:
  - Computation continues and gives RESULT=720 after E7.
  - N reads back 3.
  - A later GO gives 6.
- A GO write with wd[0]=0 and writes to a=2 or a=3 change no state. A back-to-back GO accepted in DONE clears done on that edge.
